fifo_mem_write: RTL

//  Write-domain half of the AHB2AHB bridge async FIFO. Accepts write pushes on w_clk,

---
 rtl/fifo_mem_write.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_mem_write.sv
// rtl/fifo_mem_write.sv - write-domain half of the bridge async FIFO: storage, write pointer, full/overflow
//
// Ports:
//   w_clk     write-domain clock
//   w_rstn    asynchronous active-low reset, write domain
//   w_inc     push request; w_data is taken on this edge unless w_full
//   w_data    write data word
//   r_gptr    Gray read pointer from the read domain (asynchronous to w_clk)
//   w_full    registered full flag; pushes are ignored while high
//   w_gptr    registered Gray write pointer, to the read-domain synchronizer
//   w_addr    current write address (binary pointer without its wrap bit)
//   w_ovf     sticky flag: a push was attempted while full
//   FIFO_MEM  the whole storage array, read directly by the read domain

module fifo_mem_write #(
    parameter int D_SIZE  = 16,
    parameter int F_DEPTH = 8,
    parameter int P_SIZE  = 4
) (
    input  logic              w_clk,
    input  logic              w_rstn,
    input  logic              w_inc,
    input  logic [D_SIZE-1:0] w_data,
    input  logic [P_SIZE-1:0] r_gptr,
    output logic              w_full,
    output logic [P_SIZE-1:0] w_gptr,
    output logic [P_SIZE-2:0] w_addr,
    output logic              w_ovf,
    output logic [D_SIZE-1:0] FIFO_MEM [F_DEPTH-1:0]
);

    // In Gray code, a write pointer exactly one lap ahead of the read pointer
    // differs from it in the two most significant bits only.
    localparam logic [P_SIZE-1:0] FULL_MASK = ~({P_SIZE{1'b1}} >> 2);

    logic [P_SIZE-1:0] w_bptr;
    logic [P_SIZE-1:0] rq1;
    logic [P_SIZE-1:0] rq2;
    logic [P_SIZE-1:0] bnext;
    logic [P_SIZE-1:0] gnext;
    logic              w_push;
    logic              full_next;

    assign w_addr    = w_bptr[P_SIZE-2:0];
    assign w_push    = w_inc & ~w_full;
    assign bnext     = w_bptr + P_SIZE'(w_push);
    assign gnext     = bnext ^ (bnext >> 1);
    // Compared against the synchronized read pointer only, so a read advance
    // is seen late and full can only be reported too long, never too short.
    assign full_next = (gnext == (rq2 ^ FULL_MASK));

    // Two-flop synchronizer for the read pointer.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= r_gptr;
            rq2 <= rq1;
        end
    end

    // Write pointer, full and overflow flags.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            w_bptr <= '0;
            w_gptr <= '0;
            w_full <= 1'b0;
            w_ovf  <= 1'b0;
        end else begin
            w_bptr <= bnext;
            w_gptr <= gnext;
            w_full <= full_next;
            if (w_inc && w_full) begin
                w_ovf <= 1'b1;
            end
        end
    end

    // Storage array; contents are discarded on reset.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            for (int i = 0; i < F_DEPTH; i++) begin
                FIFO_MEM[i] <= '0;
            end
        end else if (w_push) begin
            FIFO_MEM[w_addr] <= w_data;
        end
    end

endmodule
